// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer + debounce FSM per channel, clear-dominant pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses on the count channel while it is held.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clock,
  input  logic clear_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  typedef enum logic [1:0] {IDLE, RISE_WAIT, HELD, FALL_WAIT} state_t;

  // The entry sample counts as the first stable one, so the terminal value is two short.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_d;
  logic             repeat_fire;

  assign sync  = sync_q[1];
  assign level = level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse   <= press_d | repeat_fire;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = RISE_WAIT;
          cnt_d   = '0;
        end
      end
      RISE_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_TERM) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = FALL_WAIT;
          cnt_d   = '0;
        end
      end
      FALL_WAIT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if (REPEAT_EN) begin : g_repeat
    localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_q;
    logic             first_q;
    logic             in_held;

    // Counts from the press pulse; the first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign in_held     = (state_q == HELD) && sync;
    assign repeat_fire = in_held && (rep_q == (first_q ? DELAY_TERM : PERIOD_TERM));

    always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
        rep_q   <= '0;
        first_q <= 1'b1;
      end else if (!in_held) begin
        rep_q   <= '0;
        first_q <= 1'b1;
      end else if (repeat_fire) begin
        rep_q   <= '0;
        first_q <= 1'b0;
      end else begin
        rep_q <= rep_q + CNT_ONE;
      end
    end
  end else begin : g_no_repeat
    assign repeat_fire = 1'b0;
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clock,
  input  logic clear_n,
  input  logic count_btn_i,
  input  logic clear_btn_i,
  output logic count_o,
  output logic clear_o,
  output logic count_level_o,
  output logic clear_level_o
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit COUNT_REPEAT = 1'b1;
`else
  localparam bit COUNT_REPEAT = 1'b0;
`endif

  logic count_pulse;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_EN       (COUNT_REPEAT),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_count (
    .clock   (clock),
    .clear_n (clear_n),
    .btn     (count_btn_i),
    .level   (count_level_o),
    .pulse   (count_pulse)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_clear (
    .clock   (clock),
    .clear_n (clear_n),
    .btn     (clear_btn_i),
    .level   (clear_level_o),
    .pulse   (clear_o)
  );

  // Clear dominates: a count pulse coinciding with clear activity is dropped, never deferred.
  assign count_o = count_pulse & ~clear_o & ~clear_level_o;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner; a scoreboard queue holds the expected pulse cycle numbers.
// Define BTN_AUTOREPEAT_EN for both bench and RTL to check the auto-repeat build.

module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic clear_n;
  logic count_btn_i;
  logic clear_btn_i;
  logic count_o;
  logic clear_o;
  logic count_level_o;
  logic clear_level_o;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int exp_count_q[$];
  int exp_clear_q[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .count_btn_i   (count_btn_i),
    .clear_btn_i   (clear_btn_i),
    .count_o       (count_o),
    .clear_o       (clear_o),
    .count_level_o (count_level_o),
    .clear_level_o (clear_level_o)
  );

  always #5 clock = ~clock;

  // After the n-th rising edge, cyc == n.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every observed pulse must match the next expected cycle; -1 marks an unexpected pulse.
  always @(negedge clock) begin
    int e;
    if (count_o === 1'b1) begin
      e = (exp_count_q.size() != 0) ? exp_count_q.pop_front() : -1;
      check("count_o_cycle", cyc, e);
    end
    if (clear_o === 1'b1) begin
      e = (exp_clear_q.size() != 0) ? exp_clear_q.pop_front() : -1;
      check("clear_o_cycle", cyc, e);
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_count_drained"}, exp_count_q.size(), 0);
    check({tag, "_clear_drained"}, exp_clear_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int c;

    // 1: reset with both buttons high, then count held out of reset.
    clear_n     = 1'b0;
    count_btn_i = 1'b1;
    clear_btn_i = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_count_o", count_o, 0);
    check("rst_clear_o", clear_o, 0);
    check("rst_count_level", count_level_o, 0);
    check("rst_clear_level", clear_level_o, 0);
    c = cyc;
    clear_n     = 1'b1;
    clear_btn_i = 1'b0;
    exp_count_q.push_back(c + 6);
    wait_until(c + 5);
    check("t1_level_before", count_level_o, 0);
    wait_until(c + 6);
    check("t1_level_after", count_level_o, 1);
    wait_until(c + 10);
    count_btn_i = 1'b0;
    wait_until(c + 20);
    check("t1_level_released", count_level_o, 0);
    check_drained("t1");

    // 2: clean 30-cycle press, then release (no pulse on release).
    c = cyc;
    count_btn_i = 1'b1;
    exp_count_q.push_back(c + 6);
`ifdef BTN_AUTOREPEAT_EN
    exp_count_q.push_back(c + 6 + RD);
`endif
    wait_until(c + 5);
    check("t2_level_before", count_level_o, 0);
    wait_until(c + 6);
    check("t2_level_after", count_level_o, 1);
    wait_until(c + 30);
    count_btn_i = 1'b0;
    wait_until(c + 35);
    check("t2_level_hold", count_level_o, 1);
    wait_until(c + 36);
    check("t2_level_fall", count_level_o, 0);
    wait_until(c + 45);
    check_drained("t2");

    // 3: bounce every 2 cycles for 20 cycles never qualifies.
    for (int i = 0; i < 10; i++) begin
      count_btn_i = ~count_btn_i;
      repeat (2) @(negedge clock);
      check("t3_bounce_level", count_level_o, 0);
    end
    count_btn_i = 1'b0;
    repeat (10) @(negedge clock);
    check_drained("t3");

    // 3b: a D-1 cycle glitch is rejected; exactly D cycles qualifies.
    count_btn_i = 1'b1;
    repeat (D - 1) @(negedge clock);
    count_btn_i = 1'b0;
    repeat (10) @(negedge clock);
    check("t3b_short_level", count_level_o, 0);
    c = cyc;
    count_btn_i = 1'b1;
    exp_count_q.push_back(c + 6);
    repeat (D) @(negedge clock);
    count_btn_i = 1'b0;
    wait_until(c + 20);
    check_drained("t3b");

    // 4: simultaneous press -> clear only; count pressed under held clear -> nothing.
    c = cyc;
    count_btn_i = 1'b1;
    clear_btn_i = 1'b1;
    exp_clear_q.push_back(c + 6);
    wait_until(c + 6);
    check("t4_clear_level", clear_level_o, 1);
    check("t4_count_level", count_level_o, 1);
    wait_until(c + 10);
    count_btn_i = 1'b0;
    wait_until(c + 20);
    count_btn_i = 1'b1;
    wait_until(c + 35);
    check("t4_count_level2", count_level_o, 1);
    count_btn_i = 1'b0;
    clear_btn_i = 1'b0;
    wait_until(c + 50);
    check("t4_clear_released", clear_level_o, 0);
    check_drained("t4");

    // 5: reset during RISE_WAIT (cnt=2), button still held afterwards.
    c = cyc;
    count_btn_i = 1'b1;
    wait_until(c + 5);
    clear_n = 1'b0;
    @(negedge clock);
    check("t5_rst_count_o", count_o, 0);
    check("t5_rst_level", count_level_o, 0);
    wait_until(c + 8);
    clear_n = 1'b1;
    exp_count_q.push_back(c + 14);
    wait_until(c + 14);
    check("t5_level_after", count_level_o, 1);
    wait_until(c + 20);
    count_btn_i = 1'b0;
    wait_until(c + 35);
    check_drained("t5");

    // 6: long hold; auto-repeat pulses only when the feature is built in.
    c = cyc;
    count_btn_i = 1'b1;
    exp_count_q.push_back(c + 6);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 0; k < 5; k++) exp_count_q.push_back(c + 6 + RD + k * RP);
`endif
    wait_until(c + 60);
    count_btn_i = 1'b0;
    wait_until(c + 80);
    check("t6_level_released", count_level_o, 0);
    check_drained("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
